mips_cpu_hilo_muldiv: RTL and testbench
=======================================

MIPS_CPU_HILO_MULDIV -- requirements
Module: mips_cpu_hilo_muldiv

Interface
REQ-001 SHALL have port: clk  in  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port: start  in  1  request strobe, driven from the decoder's CtrlSpcRegWriteEn.
REQ-004 SHALL have port: op  in  5  decoder CtrlALUOp code: MULT=2, MULTU=22, DIV=3, DIVU=23, MTHI=24, MTLO=25.
REQ-005 SHALL have port: a  in  32  rs operand (dividend / multiplicand / MTHI-MTLO source).
REQ-006 SHALL have port: b  in  32  rt operand (divisor / multiplier).
REQ-007 SHALL have port: busy  out  1  high while an iterative operation is in progress; the core stalls on it.
REQ-008 SHALL have port: done  out  1  one-cycle pulse when hi/lo hold a new mul/div result.
REQ-009 SHALL have port: hi  out  32  HI register, feeding the MFHI write-back path.
REQ-010 SHALL have port: lo  out  32  LO register, feeding the MFLO write-back path.
REQ-011 SHALL use these parameter defaults: ITER = 32, the iteration count, fixed.

Function
REQ-012 SHALL have FSM states IDLE, RUN, FIX; busy = (state != IDLE).
REQ-013 SHALL, in IDLE with start=1 and op in {MTHI, MTLO}, write a to hi (MTHI) or lo (MTLO) at that edge; no busy, no done.
REQ-014 SHALL, in IDLE with start=1 and op in {2, 22, 3, 23}, latch a, b and op, and go to RUN with a 5-bit counter set to 0.
REQ-015 SHALL, for MULT and DIV, operate on magnitudes |a| and |b| and record the result signs; MULTU and DIVU use the raw operands.
REQ-016 SHALL perform one shift-add step (multiply) or one restoring subtract-shift step (divide) per RUN cycle, for exactly 32 cycles; counter value 31 moves the FSM to FIX.
REQ-017 SHALL, in FIX, apply sign correction and write hi/lo at the FIX edge, pulse done in the following cycle, and return to IDLE.
REQ-018 SHALL hold busy high for exactly 33 cycles; hi/lo are valid and done=1 in the 34th cycle after the start edge.
REQ-019 SHALL produce, for multiply, {hi,lo} = the 64-bit product: signed two's complement for MULT, unsigned for MULTU.
REQ-020 SHALL produce, for divide, lo = quotient truncated toward zero and hi = remainder with the sign of the dividend.
REQ-021 SHALL, for divide by zero (b=0, signed or unsigned), produce hi=a and lo=32'hFFFFFFFF.
REQ-022 SHALL, for DIV 32'h80000000 / 32'hFFFFFFFF, produce lo=32'h80000000 and hi=0.
REQ-023 SHALL ignore start while busy; operands, hi, lo and timing are unaffected, and MTHI/MTLO are also ignored in this case.
REQ-024 SHALL ignore start in IDLE when op is outside the six listed codes.
REQ-025 SHALL hold hi/lo unchanged in every cycle except the write cycles of REQ-013 and REQ-017.
REQ-026 SHALL allow a new start in the same cycle that done=1, accepting it normally.

Reset
REQ-027 SHALL, while reset=1 at a rising edge, set state=IDLE, hi=0, lo=0, busy=0, done=0 and counter=0, with priority over start.
REQ-028 SHALL abort any in-progress operation on reset without updating hi/lo with a partial result; no done pulse follows.

Structure
REQ-029 SHALL take the ALU-op code constants (MULT, MULTU, DIV, DIVU, MTHI, MTLO) from shared package mips_cpu_pkg, also imported by the decoder; the FSM state enum stays local.
REQ-030 SHALL be a single module: the shared shift/add/subtract datapath does not justify a sub-module.
REQ-031 SHALL not write the register file; the MFHI/MFLO mux stays in the CPU datapath.

Verification
REQ-032 SHALL cover: MULTU a=32'hFFFFFFFF, b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001, busy 33 cycles, done in cycle 34.
REQ-033 SHALL cover: MULT a=-3, b=7 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
REQ-034 SHALL cover: DIV a=-7, b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIVU a=7, b=0 -> hi=7, lo=32'hFFFFFFFF.
REQ-035 SHALL cover: MTHI a=32'h12345678, then MTLO a=32'hCAFEBABE on consecutive cycles -> hi/lo updated next edge, busy and done never asserted.
REQ-036 SHALL cover: DIVU start, then a second start (MTLO) at RUN cycle 5 -> ignored, original result delivered, lo not overwritten.
REQ-037 SHALL cover: MULT start, reset at RUN cycle 10 -> next cycle busy=0, hi=lo=0, no done pulse; a fresh MULT 6x7 then gives lo=42.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
// Shared CPU constants: decoder ALU-op codes and small helpers.
// Imported by the decoder and the HI/LO multiply/divide unit.
package mips_cpu_pkg;

  localparam logic [4:0] OP_MULT  = 5'd2;
  localparam logic [4:0] OP_DIV   = 5'd3;
  localparam logic [4:0] OP_MULTU = 5'd22;
  localparam logic [4:0] OP_DIVU  = 5'd23;
  localparam logic [4:0] OP_MTHI  = 5'd24;
  localparam logic [4:0] OP_MTLO  = 5'd25;

  function automatic logic [31:0] mag32(
    input logic [31:0] v,
    input logic        sgn
  );
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mips_cpu_hilo_muldiv.sv
// HI/LO unit: iterative 32-cycle multiply / restoring divide,
// plus MTHI/MTLO writes. Core stalls while busy.
module mips_cpu_hilo_muldiv
  import mips_cpu_pkg::*;
#(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  localparam logic [4:0] LAST = 5'(ITER - 1);

  state_t      state;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [31:0] opnd;
  logic        is_div;
  logic        neg_q;
  logic        neg_r;
  logic        divz;

  logic        sgn_op;
  logic        div_op;
  logic [31:0] ma;
  logic [31:0] mb;

  logic [32:0] sum;
  logic [63:0] mul_nxt;
  logic [32:0] shl;
  logic [31:0] dif;
  logic        ge;
  logic [63:0] div_nxt;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;

  assign busy = (state != IDLE);

  // Operand magnitudes and request classification at start.
  always_comb begin
    sgn_op = (op == OP_MULT) || (op == OP_DIV);
    div_op = (op == OP_DIV) || (op == OP_DIVU);
    ma     = mag32(a, sgn_op);
    mb     = mag32(b, sgn_op);
  end

  // One shift-add or restoring subtract-shift step, plus final fixup.
  always_comb begin
    sum     = {1'b0, acc[63:32]} + {1'b0, opnd};
    mul_nxt = acc[0] ? {sum, acc[31:1]}
                     : {1'b0, acc[63:32], acc[31:1]};
    shl     = {acc[63:32], acc[31]};
    ge      = (shl >= {1'b0, opnd});
    dif     = shl[31:0] - opnd;
    div_nxt = ge ? {dif, acc[30:0], 1'b1}
                 : {shl[31:0], acc[30:0], 1'b0};
    prod    = neg_q ? (~acc + 64'd1) : acc;
    quo     = neg_q ? (~acc[31:0] + 32'd1) : acc[31:0];
    rem     = neg_r ? (~acc[63:32] + 32'd1) : acc[63:32];
  end

  // Control FSM, iteration datapath and HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      acc    <= 64'd0;
      opnd   <= 32'd0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      divz   <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              OP_MULT, OP_MULTU,
              OP_DIV, OP_DIVU: begin
                state  <= RUN;
                cnt    <= 5'd0;
                is_div <= div_op;
                neg_q  <= sgn_op & (a[31] ^ b[31]);
                neg_r  <= sgn_op & div_op & a[31];
                divz   <= div_op & (b == 32'd0);
                acc    <= div_op ? {32'd0, ma} : {32'd0, mb};
                opnd   <= div_op ? mb : ma;
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          acc <= is_div ? div_nxt : mul_nxt;
          cnt <= cnt + 5'd1;
          if (cnt == LAST) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (is_div) begin
            hi <= rem;
            lo <= divz ? 32'hFFFF_FFFF : quo;
          end else begin
            hi <= prod[63:32];
            lo <= prod[31:0];
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_hilo_muldiv.sv
// Bench for the HI/LO mul/div unit: vector table,
// result scoreboard, and hand sequences for MT*, ignore and abort.
module tb_mips_cpu_hilo_muldiv;
  import mips_cpu_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [4:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  mips_cpu_hilo_muldiv dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  vec_t tv[10];
  res_t sb[$];
  int   n_cmp;
  int   n_bad;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Issue one mul/div at the current negedge and wait for done.
  // inj>0 drives an MTLO strobe during that busy cycle.
  task automatic run_op(input string       nm,
                        input logic [4:0]  op_i,
                        input logic [31:0] a_i,
                        input logic [31:0] b_i,
                        input logic [31:0] ehi,
                        input logic [31:0] elo,
                        input int          inj);
    int   n;
    int   bc;
    bit   got;
    res_t r;
    start = 1'b1;
    op    = op_i;
    a     = a_i;
    b     = b_i;
    sb.push_back('{hi: ehi, lo: elo});
    n   = 0;
    bc  = 0;
    got = 1'b0;
    while (n < 60 && !got) begin
      @(negedge clk);
      n++;
      if (n == inj) begin
        start = 1'b1;
        op    = OP_MTLO;
        a     = 32'hDEAD_BEEF;
      end else begin
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
      end
      if (done) got = 1'b1;
      else if (busy) bc++;
    end
    start = 1'b0;
    chk({nm, " done_cycle"}, 64'(n), 64'd34);
    chk({nm, " busy_cycles"}, 64'(bc), 64'd33);
    chk({nm, " busy_at_done"}, 64'(busy), 64'd0);
    r = sb.pop_front();
    chk({nm, " hi"}, 64'(hi), 64'(r.hi));
    chk({nm, " lo"}, 64'(lo), 64'(r.lo));
  endtask

  initial begin
    int dc;
    n_cmp = 0;
    n_bad = 0;

    tv[0] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
              32'hFFFFFFFE, 32'h00000001};
    tv[1] = '{OP_MULT, 32'hFFFFFFFD, 32'd7,
              32'hFFFFFFFF, 32'hFFFFFFEB};
    tv[2] = '{OP_DIV, 32'hFFFFFFF9, 32'd2,
              32'hFFFFFFFF, 32'hFFFFFFFD};
    tv[3] = '{OP_DIVU, 32'd7, 32'd0,
              32'd7, 32'hFFFFFFFF};
    tv[4] = '{OP_DIV, 32'h80000000, 32'hFFFFFFFF,
              32'd0, 32'h80000000};
    tv[5] = '{OP_MULT, 32'h80000000, 32'h80000000,
              32'h40000000, 32'd0};
    tv[6] = '{OP_DIV, 32'hFFFFFFF7, 32'd0,
              32'hFFFFFFF7, 32'hFFFFFFFF};
    tv[7] = '{OP_DIVU, 32'hFFFFFFFF, 32'd10,
              32'd5, 32'h19999999};
    tv[8] = '{OP_MULTU, 32'h12345678, 32'd9,
              32'd0, 32'hA3D70A38};
    tv[9] = '{OP_DIV, 32'd7, 32'hFFFFFFFE,
              32'd1, 32'hFFFFFFFD};

    reset = 1'b1;
    start = 1'b1;
    op    = OP_MTHI;
    a     = 32'h1111_1111;
    b     = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst hi", 64'(hi), 64'd0);
    chk("rst lo", 64'(lo), 64'd0);
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    // Back-to-back: each new start lands in the prior done cycle.
    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), tv[i].op, tv[i].a,
             tv[i].b, tv[i].hi, tv[i].lo, 0);
    end

    @(negedge clk);
    start = 1'b1;
    op    = OP_MTHI;
    a     = 32'h12345678;
    @(negedge clk);
    chk("mthi hi", 64'(hi), 64'h12345678);
    chk("mthi busy", 64'(busy), 64'd0);
    chk("mthi done", 64'(done), 64'd0);
    op = OP_MTLO;
    a  = 32'hCAFEBABE;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo lo", 64'(lo), 64'hCAFEBABE);
    chk("mtlo hi", 64'(hi), 64'h12345678);
    chk("mtlo busy", 64'(busy), 64'd0);
    chk("mtlo done", 64'(done), 64'd0);

    start = 1'b1;
    op    = 5'd7;
    a     = 32'd1;
    b     = 32'd1;
    @(negedge clk);
    start = 1'b0;
    chk("badop busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("badop done", 64'(done), 64'd0);
    chk("badop hilo", {hi, lo}, 64'h12345678_CAFEBABE);

    run_op("divu_inj", OP_DIVU, 32'd100, 32'd7,
           32'd2, 32'd14, 5);

    @(negedge clk);
    start = 1'b1;
    op    = OP_MULT;
    a     = 32'd12345;
    b     = 32'd678;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort hi", 64'(hi), 64'd0);
    chk("abort lo", 64'(lo), 64'd0);
    dc = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dc++;
    end
    chk("abort no_done", 64'(dc), 64'd0);
    chk("abort hilo_hold", {hi, lo}, 64'd0);

    run_op("mult6x7", OP_MULT, 32'd6, 32'd7, 32'd0, 32'd42, 0);

    chk("sb empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
